// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    // Fetch sequencing states
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    // Clear the byte-offset bits so every fetch address is word aligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'(INSTR_BYTES - 1);
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// One-entry output holding register between instruction memory and decode.
// A flush drops the held word immediately and wins over load and consume.
module fetch_buffer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        in_valid_i,
    input  logic [31:0] in_data_i,
    input  logic [31:0] in_pc_i,
    output logic        out_valid_o,
    output logic [31:0] out_data_o,
    output logic [31:0] out_pc_o,
    input  logic        out_ready_i
);

    logic        valid_q, valid_d;
    logic [31:0] data_q,  data_d;
    logic [31:0] pc_q,    pc_d;

    // Next-entry selection: flush, then consume, then load
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        pc_d    = pc_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
        end else if (in_valid_i) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
            pc_d    = in_pc_i;
        end
    end

    // Entry register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= 32'h0;
            pc_q    <= 32'h0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            pc_q    <= pc_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_pc_o    = pc_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: issues one word read at a time, holds the
// returned word for decode, and restarts on redirect.
// Optional build macro FETCH_PERF_CNT_EN adds the fetch_count output.
//
// state | meaning
// REQ   | request pc from memory (held off while a flushed response is due)
// WAIT  | one request outstanding, waiting for its response
// HOLD  | word offered to decode until consumed
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         flush_q, flush_d;
    logic         req_en_q;
    logic         req_fire;
    logic         rsp_accept;

    // req_en_q keeps the request low until the first edge after reset release.
    // While flush_q is set a dropped response is still due, so no new request
    // goes out: at most one request is ever in flight.
    assign mem_req_valid = req_en_q && (state_q == REQ) && !flush_q;
    assign mem_req_addr  = pc_q;
    assign req_fire      = mem_req_valid && mem_req_ready;
    assign rsp_accept    = (state_q == WAIT) && mem_rsp_valid && !flush_q && !redirect_valid;

    // Next-state, next-pc and flush tracking; redirect overrides everything
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flush_d = flush_q;
        if (flush_q && mem_rsp_valid) begin
            flush_d = 1'b0;
        end
        if (redirect_valid) begin
            pc_d    = align_word(redirect_pc);
            state_d = REQ;
            case (state_q)
                REQ:     if (req_fire) flush_d = 1'b1;
                WAIT:    if (!mem_rsp_valid) flush_d = 1'b1;
                default: ;
            endcase
        end else begin
            case (state_q)
                REQ: begin
                    if (req_fire) state_d = WAIT;
                end
                WAIT: begin
                    if (mem_rsp_valid) state_d = HOLD;
                end
                HOLD: begin
                    if (instr_ready) begin
                        pc_d    = pc_q + 32'(INSTR_BYTES);
                        state_d = REQ;
                    end
                end
                default: state_d = REQ;
            endcase
        end
    end

    // FSM, pc and flush registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
        end
    end

    // Request enable: first rising edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_en_q <= 1'b0;
        end else begin
            req_en_q <= 1'b1;
        end
    end

    fetch_buffer u_buffer (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (redirect_valid),
        .in_valid_i  (rsp_accept),
        .in_data_i   (mem_rsp_data),
        .in_pc_i     (pc_q),
        .out_valid_o (instr_valid),
        .out_data_o  (instr_data),
        .out_pc_o    (instr_pc),
        .out_ready_i (instr_ready)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] count_q;

    // Count consumed words; a redirect in the same cycle cancels the consume
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 32'h0;
        end else if (instr_valid && instr_ready && !redirect_valid) begin
            count_q <= count_q + 32'h1;
        end
    end

    assign fetch_count = count_q;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller.
module tb_fetch_controller;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_ready;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
`endif

    fetch_controller #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count    (fetch_count)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // knobs written by the main thread only
    logic k_mem_ready = 1'b1;
    int   k_lat       = 0;
    logic k_inject    = 1'b0;

    // memory / model state written by the negedge process only
    logic        pend      = 1'b0;
    logic        stale     = 1'b0;
    int          cnt       = 0;
    logic [31:0] pend_addr = 32'h0;
    logic        last_good = 1'b0;
    logic        prev_rst  = 1'b0;
    logic        prev_iv   = 1'b0;
    int          n_accept  = 0;
    logic [31:0] m_pc      = RST_PC;
    logic [31:0] m_cnt     = 32'h0;
    logic [31:0] dlog[$];

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, 32'(act), 32'(exp));
    endtask

    // Memory responder, per-cycle output checks and reference model.
    // The model only knows the architectural rule: the next word delivered
    // (and the address being requested) is the current program counter, which
    // moves by 4 on every consume and jumps on every redirect.
    always @(negedge clk) begin
        logic pend_at_start;
        pend_at_start = pend;

        if (!rst_n) begin
            chk1("rst_req_valid", mem_req_valid, 1'b0);
            chk1("rst_instr_valid", instr_valid, 1'b0);
            chk("rst_instr_data", instr_data, 32'h0);
            chk("rst_instr_pc", instr_pc, 32'h0);
        end else begin
            if (!prev_rst) chk1("req_before_first_edge", mem_req_valid, 1'b0);
            if (mem_req_valid) begin
                chk("req_addr", mem_req_addr, m_pc);
                chk1("single_outstanding", pend_at_start, 1'b0);
            end
            if (instr_valid) begin
                chk("instr_pc", instr_pc, m_pc);
                chk("instr_data", instr_data, memfn(m_pc));
                chk1("no_req_in_hold", mem_req_valid, 1'b0);
            end
            if (last_good || (instr_valid && !prev_iv))
                chk1("rsp_to_valid_latency", instr_valid && !prev_iv, last_good);
`ifdef FETCH_PERF_CNT_EN
            chk("fetch_count", fetch_count, m_cnt);
`endif
        end

        // memory side
        mem_rsp_valid = 1'b0;
        last_good     = 1'b0;
        if (!rst_n) begin
            pend          = 1'b0;
            mem_req_ready = 1'b0;
        end else begin
            if (pend) begin
                if (cnt == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = memfn(pend_addr);
                    last_good     = !stale && !redirect_valid;
                    pend          = 1'b0;
                end else begin
                    cnt = cnt - 1;
                    if (redirect_valid) stale = 1'b1;
                end
            end
            if (k_inject) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = 32'hDEAD_BEEF;
                last_good     = 1'b0;
            end
            mem_req_ready = k_mem_ready;
            if (mem_req_valid && mem_req_ready) begin
                pend      = 1'b1;
                cnt       = k_lat;
                stale     = redirect_valid;
                pend_addr = mem_req_addr;
                n_accept++;
            end
        end

        // model update for the coming edge
        if (!rst_n) begin
            m_pc  = RST_PC;
            m_cnt = 32'h0;
        end else if (redirect_valid) begin
            m_pc = redirect_pc & 32'hFFFF_FFFC;
        end else if (instr_valid && instr_ready) begin
            dlog.push_back(m_pc);
            m_pc  = m_pc + 32'd4;
            m_cnt = m_cnt + 32'd1;
        end

        prev_rst = rst_n;
        prev_iv  = instr_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_log(input int n, input string name);
        for (int i = 0; i < 200 && dlog.size() < n; i++) tick();
        chk1(name, dlog.size() >= n, 1'b1);
    endtask

    task automatic wait_iv(input string name);
        for (int i = 0; i < 100 && !instr_valid; i++) tick();
        chk1(name, instr_valid, 1'b1);
    endtask

    task automatic wait_req(input string name);
        for (int i = 0; i < 100 && !mem_req_valid; i++) tick();
        chk1(name, mem_req_valid, 1'b1);
    endtask

    task automatic wait_pend(input string name);
        for (int i = 0; i < 100 && !pend; i++) tick();
        chk1(name, pend, 1'b1);
    endtask

    initial begin
        logic [31:0] d0, p0, a0;
        int          acc0, n;

        rst_n          = 1'b0;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        mem_rsp_data   = 32'h0;
        repeat (3) tick();
        rst_n = 1'b1;

        // sequential fetch, memory always ready, one-cycle response
        wait_log(3, "seq_timeout");
        chk("seq_pc0", dlog[0], 32'h0000_0000);
        chk("seq_pc1", dlog[1], 32'h0000_0004);
        chk("seq_pc2", dlog[2], 32'h0000_0008);

        // decode stalls for 5 cycles in HOLD
        instr_ready = 1'b0;
        wait_iv("hold_timeout");
        d0 = instr_data;
        p0 = instr_pc;
        chk("hold_pc_lit", p0, 32'h0000_000C);
        chk("hold_data_lit", d0, memfn(32'h0000_000C));
        repeat (5) begin
            tick();
            chk1("hold_valid", instr_valid, 1'b1);
            chk("hold_data_stable", instr_data, d0);
            chk("hold_pc_stable", instr_pc, p0);
            chk1("hold_no_req", mem_req_valid, 1'b0);
        end

        // redirect while a response is outstanding
        k_lat       = 3;
        instr_ready = 1'b1;
        wait_pend("wait_state_timeout");
        redirect_pc    = 32'h0000_1003;
        redirect_valid = 1'b1;
        tick();
        redirect_valid = 1'b0;
        k_lat          = 0;
        n = dlog.size();
        wait_req("redir_wait_req_timeout");
        chk("redir_wait_addr", mem_req_addr, 32'h0000_1000);
        wait_log(n + 1, "redir_wait_deliver_timeout");
        chk("redir_wait_first", dlog[$], 32'h0000_1000);

        // memory not ready for 3 cycles
        k_mem_ready = 1'b0;
        wait_req("stall_req_timeout");
        tick();
        instr_ready = 1'b0;
        wait_req("stall_req2_timeout");
        a0   = mem_req_addr;
        acc0 = n_accept;
        repeat (3) begin
            tick();
            chk1("stall_req_valid", mem_req_valid, 1'b1);
            chk("stall_addr_stable", mem_req_addr, a0);
        end
        k_mem_ready = 1'b1;
        wait_iv("stall_deliver_timeout");
        chk("stall_single_accept", 32'(n_accept - acc0), 32'd1);
        chk("stall_pc", instr_pc, a0);
        instr_ready = 1'b1;

        // redirect in REQ with a same-cycle accepted request
        wait_req("redir_req_timeout");
        redirect_pc    = 32'h0000_0202;
        redirect_valid = 1'b1;
        tick();
        redirect_valid = 1'b0;
        n = dlog.size();
        wait_log(n + 1, "redir_req_deliver_timeout");
        chk("redir_req_first", dlog[$], 32'h0000_0200);

        // redirect in HOLD (with instr_ready high) to the top word, then wrap
        instr_ready = 1'b0;
        wait_iv("redir_hold_timeout");
        redirect_pc    = 32'hFFFF_FFFE;
        redirect_valid = 1'b1;
        instr_ready    = 1'b1;
        tick();
        redirect_valid = 1'b0;
        chk1("redir_hold_drop", instr_valid, 1'b0);
        n = dlog.size();
        wait_log(n + 2, "wrap_timeout");
        chk("wrap_top", dlog[$-1], 32'hFFFF_FFFC);
        chk("wrap_zero", dlog[$], 32'h0000_0000);

        // reset while waiting; a late response must be ignored
        k_lat = 5;
        wait_pend("rst_wait_timeout");
        rst_n = 1'b0;
        tick();
        tick();
        k_mem_ready = 1'b0;
        rst_n       = 1'b1;
        tick();
        k_inject = 1'b1;
        tick();
        k_inject = 1'b0;
        tick();
        tick();
        chk1("late_rsp_ignored", instr_valid, 1'b0);
        chk1("restart_req", mem_req_valid, 1'b1);
        chk("restart_addr", mem_req_addr, RST_PC);
`ifdef FETCH_PERF_CNT_EN
        chk("count_after_reset", fetch_count, 32'h0);
`endif
        k_lat       = 0;
        k_mem_ready = 1'b1;
        n = dlog.size();
        wait_log(n + 1, "restart_timeout");
        chk("restart_first", dlog[$], RST_PC);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

endmodule
